// File: rtl/axi4lite_slave_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel state encodings.
// Used by both the slave and the existing AXI4-Lite master.
package axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_HAVE_ADDR,
      WR_HAVE_DATA,
      WR_RESP
   } wr_state_t;

   typedef enum logic {
      RD_IDLE,
      RD_DATA
   } rd_state_t;

   // Only word-aligned byte addresses map onto a register.
   function automatic logic [1:0] resp_for(input logic [1:0] addr_lsbs);
      return (addr_lsbs == 2'b00) ? RESP_OKAY : RESP_SLVERR;
   endfunction

endpackage

// File: rtl/axi4lite_slave_if.sv
// AXI4-Lite bus bundle: the five channels between one master and one slave.
interface axi4lite_slave_if #(
   parameter int data_width    = 32,
   parameter int address_width = 6
) ();

   logic [address_width-1:0] AWADDR;
   logic                     AWVALID;
   logic                     AWREADY;
   logic [data_width-1:0]    WDATA;
   logic                     WVALID;
   logic                     WREADY;
   logic                     BVALID;
   logic [1:0]               BRESP;
   logic                     BREADY;
   logic [address_width-1:0] ARADDR;
   logic                     ARVALID;
   logic                     ARREADY;
   logic                     RVALID;
   logic [data_width-1:0]    RDATA;
   logic [1:0]               RRESP;
   logic                     RREADY;

   modport slave (
      input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );

   modport master (
      output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );

endinterface

// File: rtl/axi4lite_slave_regfile.sv
// Register storage behind the slave: one write port, one combinational read
// port, and every register exported flat to the surrounding fabric.
module axi4lite_regfile #(
   parameter int data_width = 32,
   parameter int num_regs   = 16,
   localparam int idx_width = $clog2(num_regs)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           we,
   input  logic [idx_width-1:0]           widx,
   input  logic [data_width-1:0]          wdata,
   input  logic [idx_width-1:0]           ridx,
   output logic [data_width-1:0]          rdata,
   output logic [num_regs*data_width-1:0] regs_o
);

   logic [data_width-1:0] regs [num_regs];

   always_ff @(posedge clk) begin
      // NOTE: these are software-visible control registers that must read 0
      // after reset, so the whole array is reset; a plain data RAM would not be.
      if (!rst_n) begin
         for (int k = 0; k < num_regs; k++) regs[k] <= '0;
      end else if (we) begin
         regs[widx] <= wdata;
      end
   end

   assign rdata = regs[ridx];

   for (genvar k = 0; k < num_regs; k++) begin : g_flat
      assign regs_o[k*data_width +: data_width] = regs[k];
   end

endmodule

// File: rtl/axi4lite_slave.sv
// AXI4-Lite responder over a word-addressed register file; the write and read
// channels are served by independent state machines.
module axi4lite_slave
   import axi4lite_pkg::*;
#(
   parameter int data_width    = 32,
   parameter int address_width = 6,
   localparam int NUM_REGS     = 2 ** (address_width - 2),
   localparam int idx_width    = address_width - 2
) (
   input  logic                           ACLK,
   input  logic                           ARESET_N,
   axi4lite_slave_if.slave                bus,
   output logic [NUM_REGS*data_width-1:0] regs_o
);

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;

   logic                     aw_ready, w_ready, b_valid;
   logic                     ar_ready, r_valid;
   logic                     aw_hs, w_hs, ar_hs;
   logic                     commit, we;
   logic [address_width-1:0] aw_addr_q, commit_addr;
   logic [data_width-1:0]    w_data_q, commit_data, reg_rdata, rdata_q;
   logic [1:0]               bresp_q, rresp_q;

   assign aw_hs = bus.AWVALID && aw_ready;
   assign w_hs  = bus.WVALID  && w_ready;
   assign ar_hs = bus.ARVALID && ar_ready;

   // ---------------- write channel ----------------
   always_ff @(posedge ACLK) begin
      // NOTE: every clocked process uses non-blocking assignments so all
      // state updates see the values from before the edge.
      if (!ARESET_N) wr_state <= WR_IDLE;
      else           wr_state <= wr_next;
   end

   always_comb begin
      // NOTE: defaults first, so no path through the case leaves a latch.
      wr_next = wr_state;
      commit  = 1'b0;
      unique case (wr_state)
         WR_IDLE: begin
            if (aw_hs && w_hs) begin
               commit  = 1'b1;
               wr_next = WR_RESP;
            end else if (aw_hs) begin
               wr_next = WR_HAVE_ADDR;
            end else if (w_hs) begin
               wr_next = WR_HAVE_DATA;
            end
         end
         WR_HAVE_ADDR: if (w_hs) begin
            commit  = 1'b1;
            wr_next = WR_RESP;
         end
         WR_HAVE_DATA: if (aw_hs) begin
            commit  = 1'b1;
            wr_next = WR_RESP;
         end
         WR_RESP: if (bus.BREADY) wr_next = WR_IDLE;
         default: wr_next = WR_IDLE;
      endcase
   end

   always_comb begin
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      unique case (wr_state)
         WR_IDLE:      begin aw_ready = 1'b1; w_ready = 1'b1; end
         WR_HAVE_ADDR: w_ready  = 1'b1;
         WR_HAVE_DATA: aw_ready = 1'b1;
         WR_RESP:      b_valid  = 1'b1;
         default:      b_valid  = 1'b0;
      endcase
   end

   // Commit uses whichever half was held plus the half arriving this edge.
   assign commit_addr = (wr_state == WR_HAVE_ADDR) ? aw_addr_q : bus.AWADDR;
   assign commit_data = (wr_state == WR_HAVE_DATA) ? w_data_q  : bus.WDATA;
   assign we          = commit && (commit_addr[1:0] == 2'b00);

   always_ff @(posedge ACLK) begin
      if (!ARESET_N) begin
         aw_addr_q <= '0;
         w_data_q  <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         if (aw_hs)  aw_addr_q <= bus.AWADDR;
         if (w_hs)   w_data_q  <= bus.WDATA;
         if (commit) bresp_q   <= resp_for(commit_addr[1:0]);
      end
   end

   // ---------------- read channel ----------------
   always_ff @(posedge ACLK) begin
      if (!ARESET_N) rd_state <= RD_IDLE;
      else           rd_state <= rd_next;
   end

   always_comb begin
      rd_next = rd_state;
      unique case (rd_state)
         RD_IDLE: if (ar_hs)      rd_next = RD_DATA;
         RD_DATA: if (bus.RREADY) rd_next = RD_IDLE;
         default: rd_next = RD_IDLE;
      endcase
   end

   always_comb begin
      ar_ready = (rd_state == RD_IDLE);
      r_valid  = (rd_state == RD_DATA);
   end

   // The register file is read before this edge's write lands, so a read and
   // write to the same word on one edge return the old contents.
   always_ff @(posedge ACLK) begin
      if (!ARESET_N) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (ar_hs) begin
         rdata_q <= (bus.ARADDR[1:0] == 2'b00) ? reg_rdata : '0;
         rresp_q <= resp_for(bus.ARADDR[1:0]);
      end
   end

   axi4lite_regfile #(
      .data_width (data_width),
      .num_regs   (NUM_REGS)
   ) u_regfile (
      .clk    (ACLK),
      .rst_n  (ARESET_N),
      .we     (we),
      .widx   (commit_addr[address_width-1:2]),
      .wdata  (commit_data),
      .ridx   (bus.ARADDR[address_width-1:2]),
      .rdata  (reg_rdata),
      .regs_o (regs_o)
   );

   assign bus.AWREADY = aw_ready;
   assign bus.WREADY  = w_ready;
   assign bus.BVALID  = b_valid;
   assign bus.BRESP   = bresp_q;
   assign bus.ARREADY = ar_ready;
   assign bus.RVALID  = r_valid;
   assign bus.RDATA   = rdata_q;
   assign bus.RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4lite_slave.sv
// Bench for axi4lite_slave: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_axi4lite_slave;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int NR = 16;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR*DW-1:0] regs_o;

   axi4lite_slave_if #(.data_width(DW), .address_width(AW)) bus ();

   axi4lite_slave #(.data_width(DW), .address_width(AW)) dut (
      .ACLK     (clk),
      .ARESET_N (rst_n),
      .bus      (bus.slave),
      .regs_o   (regs_o)
   );

   always #5 clk = ~clk;

   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic [DW-1:0] m_regs [NR];
   bit            m_live, m_aw_held, m_w_held, m_b_valid, m_r_valid, m_b_fresh, m_r_fresh;
   logic [AW-1:0] m_aw_addr;
   logic [DW-1:0] m_w_data, m_rdata;
   logic [1:0]    m_bresp, m_rresp;

   function automatic bit exp_awready();
      return !m_aw_held && !m_b_valid;
   endfunction

   function automatic bit exp_wready();
      return !m_w_held && !m_b_valid;
   endfunction

   task automatic model_step();
      bit            aw_fire, w_fire, ar_fire;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      if (!rst_n) begin
         for (int k = 0; k < NR; k++) m_regs[k] = '0;
         m_live    = 1'b1;
         m_aw_held = 1'b0;
         m_w_held  = 1'b0;
         m_b_valid = 1'b0;
         m_r_valid = 1'b0;
         m_b_fresh = 1'b1;
         m_r_fresh = 1'b1;
         m_bresp   = 2'b00;
         m_rresp   = 2'b00;
         m_rdata   = '0;
         return;
      end
      if (!m_live) return;
      aw_fire = bus.AWVALID && exp_awready();
      w_fire  = bus.WVALID  && exp_wready();
      ar_fire = bus.ARVALID && !m_r_valid;
      // Read sees the register contents from before any write on this edge.
      if (ar_fire) begin
         m_r_valid = 1'b1;
         m_r_fresh = 1'b0;
         if (bus.ARADDR[1:0] == 2'b00) begin
            m_rdata = m_regs[bus.ARADDR[AW-1:2]];
            m_rresp = 2'b00;
         end else begin
            m_rdata = '0;
            m_rresp = 2'b10;
         end
      end else if (m_r_valid && bus.RREADY) begin
         m_r_valid = 1'b0;
      end
      if (m_b_valid) begin
         if (bus.BREADY) m_b_valid = 1'b0;
      end else begin
         a = aw_fire ? bus.AWADDR : m_aw_addr;
         d = w_fire  ? bus.WDATA  : m_w_data;
         if ((aw_fire || m_aw_held) && (w_fire || m_w_held)) begin
            if (a[1:0] == 2'b00) m_regs[a[AW-1:2]] = d;
            m_bresp   = (a[1:0] == 2'b00) ? 2'b00 : 2'b10;
            m_b_valid = 1'b1;
            m_b_fresh = 1'b0;
            m_aw_held = 1'b0;
            m_w_held  = 1'b0;
         end else begin
            if (aw_fire) begin m_aw_held = 1'b1; m_aw_addr = bus.AWADDR; end
            if (w_fire)  begin m_w_held  = 1'b1; m_w_data  = bus.WDATA;  end
         end
      end
   endtask

   always @(posedge clk) model_step();

   // Outputs are registered, so the falling edge is a stable sampling point.
   always @(negedge clk) begin
      if (m_live) begin
         check("AWREADY", 64'(bus.AWREADY), 64'(exp_awready()));
         check("WREADY",  64'(bus.WREADY),  64'(exp_wready()));
         check("BVALID",  64'(bus.BVALID),  64'(m_b_valid));
         check("ARREADY", 64'(bus.ARREADY), 64'(!m_r_valid));
         check("RVALID",  64'(bus.RVALID),  64'(m_r_valid));
         if (m_b_valid || m_b_fresh) check("BRESP", 64'(bus.BRESP), 64'(m_bresp));
         if (m_r_valid || m_r_fresh) begin
            check("RDATA", 64'(bus.RDATA), 64'(m_rdata));
            check("RRESP", 64'(bus.RRESP), 64'(m_rresp));
         end
         for (int k = 0; k < NR; k++)
            check($sformatf("regs_o[%0d]", k), 64'(regs_o[k*DW +: DW]), 64'(m_regs[k]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      bus.AWVALID = 1'b0; bus.AWADDR = '0;
      bus.WVALID  = 1'b0; bus.WDATA  = '0;
      bus.BREADY  = 1'b0;
      bus.ARVALID = 1'b0; bus.ARADDR = '0;
      bus.RREADY  = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_d,
                          input logic [1:0] exp_r, input int lag, input string tag);
      bus.ARVALID = 1'b1;
      bus.ARADDR  = addr;
      bus.RREADY  = 1'b0;
      @(negedge clk);
      bus.ARVALID = 1'b0;
      check({tag, " RVALID"}, 64'(bus.RVALID), 64'd1);
      check({tag, " RDATA"},  64'(bus.RDATA),  64'(exp_d));
      check({tag, " RRESP"},  64'(bus.RRESP),  64'(exp_r));
      repeat (lag) begin
         @(negedge clk);
         check({tag, " RDATA held"}, 64'(bus.RDATA),  64'(exp_d));
         check({tag, " RVALID held"}, 64'(bus.RVALID), 64'd1);
      end
      bus.RREADY = 1'b1;
      @(negedge clk);
      bus.RREADY = 1'b0;
      check({tag, " RVALID drop"}, 64'(bus.RVALID), 64'd0);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return AW'($urandom);
      return {4'($urandom_range(0, NR - 1)), 2'b00};
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, " BVALID"},  64'(bus.BVALID),  64'd0);
      check({tag, " RVALID"},  64'(bus.RVALID),  64'd0);
      check({tag, " BRESP"},   64'(bus.BRESP),   64'd0);
      check({tag, " RRESP"},   64'(bus.RRESP),   64'd0);
      check({tag, " RDATA"},   64'(bus.RDATA),   64'd0);
      check({tag, " AWREADY"}, 64'(bus.AWREADY), 64'd1);
      check({tag, " WREADY"},  64'(bus.WREADY),  64'd1);
      check({tag, " ARREADY"}, 64'(bus.ARREADY), 64'd1);
      check({tag, " regs_o"},  64'(|regs_o),     64'd0);
   endtask

   logic [NR*DW-1:0] snap;

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_reset_outputs("reset");

      // Address and data together.
      bus.AWVALID = 1'b1; bus.AWADDR = 6'h08;
      bus.WVALID  = 1'b1; bus.WDATA  = 32'hDEADBEEF;
      bus.BREADY  = 1'b1;
      @(negedge clk);
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      check("t1 BVALID", 64'(bus.BVALID), 64'd1);
      check("t1 BRESP",  64'(bus.BRESP),  64'd0);
      check("t1 reg2",   64'(regs_o[2*DW +: DW]), 64'h0000_0000_DEAD_BEEF);
      @(negedge clk);
      bus.BREADY = 1'b0;
      check("t1 BVALID drop", 64'(bus.BVALID), 64'd0);
      do_read(6'h08, 32'hDEADBEEF, 2'b00, 0, "t1 read");

      // Data three cycles ahead of the address.
      bus.WVALID = 1'b1; bus.WDATA = 32'h12345678;
      @(negedge clk);
      bus.WVALID = 1'b0;
      check("t2 WREADY",  64'(bus.WREADY),  64'd0);
      check("t2 AWREADY", 64'(bus.AWREADY), 64'd1);
      check("t2 BVALID",  64'(bus.BVALID),  64'd0);
      repeat (2) @(negedge clk);
      bus.AWVALID = 1'b1; bus.AWADDR = 6'h3C;
      @(negedge clk);
      bus.AWVALID = 1'b0;
      check("t2 BVALID", 64'(bus.BVALID), 64'd1);
      check("t2 BRESP",  64'(bus.BRESP),  64'd0);
      bus.BREADY = 1'b1;
      @(negedge clk);
      bus.BREADY = 1'b0;
      do_read(6'h3C, 32'h12345678, 2'b00, 0, "t2 read");

      // Misaligned write and read.
      snap = regs_o;
      bus.AWVALID = 1'b1; bus.AWADDR = 6'h05;
      bus.WVALID  = 1'b1; bus.WDATA  = 32'hFFFFFFFF;
      bus.BREADY  = 1'b1;
      @(negedge clk);
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      check("t3 BVALID", 64'(bus.BVALID), 64'd1);
      check("t3 BRESP",  64'(bus.BRESP),  64'd2);
      check("t3 regs changed", 64'(regs_o != snap), 64'd0);
      @(negedge clk);
      bus.BREADY = 1'b0;
      do_read(6'h05, 32'h0, 2'b10, 0, "t3 read");

      // Back-pressure on B and R.
      bus.AWVALID = 1'b1; bus.AWADDR = 6'h00;
      bus.WVALID  = 1'b1; bus.WDATA  = 32'h11111111;
      @(negedge clk);
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      repeat (4) begin
         check("t4 BVALID",  64'(bus.BVALID),  64'd1);
         check("t4 BRESP",   64'(bus.BRESP),   64'd0);
         check("t4 AWREADY", 64'(bus.AWREADY), 64'd0);
         check("t4 WREADY",  64'(bus.WREADY),  64'd0);
         @(negedge clk);
      end
      bus.BREADY = 1'b1;
      @(negedge clk);
      bus.BREADY = 1'b0;
      do_read(6'h00, 32'h11111111, 2'b00, 3, "t4 read");

      // Read and write of the same word on one edge.
      bus.AWVALID = 1'b1; bus.AWADDR = 6'h0C;
      bus.WVALID  = 1'b1; bus.WDATA  = 32'hA5A5A5A5;
      bus.ARVALID = 1'b1; bus.ARADDR = 6'h0C;
      @(negedge clk);
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      check("t5 RVALID", 64'(bus.RVALID), 64'd1);
      check("t5 RDATA",  64'(bus.RDATA),  64'd0);
      check("t5 BVALID", 64'(bus.BVALID), 64'd1);
      check("t5 reg3",   64'(regs_o[3*DW +: DW]), 64'h0000_0000_A5A5_A5A5);
      bus.RREADY = 1'b1; bus.BREADY = 1'b1;
      @(negedge clk);
      bus.RREADY = 1'b0; bus.BREADY = 1'b0;
      do_read(6'h0C, 32'hA5A5A5A5, 2'b00, 0, "t5 read");

      // Reset between address and data.
      bus.AWVALID = 1'b1; bus.AWADDR = 6'h10;
      @(negedge clk);
      bus.AWVALID = 1'b0;
      check("t6 AWREADY held", 64'(bus.AWREADY), 64'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_outputs("t6 reset");
      bus.WVALID = 1'b1; bus.WDATA = 32'h1; bus.BREADY = 1'b1;
      @(negedge clk);
      bus.WVALID = 1'b0;
      check("t6 BVALID", 64'(bus.BVALID), 64'd0);
      check("t6 reg4",   64'(regs_o[4*DW +: DW]), 64'd0);
      @(negedge clk);
      check("t6 BVALID later", 64'(bus.BVALID), 64'd0);
      bus.BREADY = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic; the compare process does the checking.
      for (int i = 0; i < 3000; i++) begin
         bus.AWVALID = 1'($urandom_range(0, 1));
         bus.AWADDR  = rand_addr();
         bus.WVALID  = 1'($urandom_range(0, 1));
         bus.WDATA   = DW'($urandom);
         bus.BREADY  = ($urandom_range(0, 9) < 6);
         bus.ARVALID = 1'($urandom_range(0, 1));
         bus.ARADDR  = rand_addr();
         bus.RREADY  = ($urandom_range(0, 9) < 6);
         rst_n       = ($urandom_range(0, 299) != 0);
         @(negedge clk);
      end
      idle_inputs();
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/axi4lite_slave.md
Name: axi4lite_slave

Overview:
AXI4-Lite responder that terminates the write-address, write-data, write-response, read-address and read-data channels. Backs them with a word-addressed register file of 2**(address_width-2) registers. Pairs with the existing AXI4-Lite master and exposes all register contents to the surrounding fabric. Write and read paths run as independent state machines.

Parameters:
data_width, 32, register and bus data width in bits
address_width, 6, byte address width; word index = ADDR[address_width-1:2]
NUM_REGS, 2**(address_width-2) (derived localparam, 16), register count

Ports:
ACLK  input  1  clock, all logic on rising edge
ARESET_N  input  1  reset, synchronous, active-low
AWADDR  input  address_width  write address
AWVALID  input  1  write address valid
AWREADY  output  1  write address ready
WDATA  input  data_width  write data
WVALID  input  1  write data valid
WREADY  output  1  write data ready
BVALID  output  1  write response valid
BRESP  output  2  write response
BREADY  input  1  write response ready
ARADDR  input  address_width  read address
ARVALID  input  1  read address valid
ARREADY  output  1  read address ready
RVALID  output  1  read data valid
RDATA  output  data_width  read data
RRESP  output  2  read response
RREADY  input  1  read data ready
regs_o  output  NUM_REGS*data_width  flattened register contents, reg k at [k*data_width +: data_width]

Behaviour:
- Reset (ARESET_N low at a rising edge):
  - all registers = 0
  - BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0
  - aw_held/w_held flags cleared
  - Reset mid-transaction drops any partially captured write and any pending response; no register is modified on that edge.
- Handshake: a transfer occurs on an edge where VALID and READY are both 1. READY does not depend combinationally on VALID. Captured address/data are held until used.
- Write FSM states:
  - WR_IDLE: AWREADY=1, WREADY=1.
  - WR_HAVE_ADDR: address held; AWREADY=0, WREADY=1.
  - WR_HAVE_DATA: data held; AWREADY=1, WREADY=0.
  - WR_RESP: BVALID=1, AWREADY=0, WREADY=0.
- Write transitions:
  - IDLE: AW only -> HAVE_ADDR; W only -> HAVE_DATA; both on the same edge -> commit -> RESP.
  - HAVE_ADDR + W handshake -> commit -> RESP.
  - HAVE_DATA + AW handshake -> commit -> RESP.
  - RESP + BREADY -> IDLE. BVALID/BRESP stay stable until BREADY.
- Commit: performed on the completing edge using the incoming or held values. BVALID rises on that same edge, so latency is 1 cycle from the last of AW/W to BVALID.
- Address check:
  - ADDR[1:0]==0 -> register written, BRESP=OKAY (2'b00).
  - ADDR[1:0]!=0 -> no write, BRESP=SLVERR (2'b10).
- Read FSM states:
  - RD_IDLE: ARREADY=1, RVALID=0.
  - RD_DATA: ARREADY=0, RVALID=1.
- Read transitions:
  - AR handshake -> RDATA/RRESP loaded, -> RD_DATA.
  - RD_DATA + RREADY -> RD_IDLE.
  - RDATA and RRESP are held stable while RVALID=1 and RREADY=0.
  - No back-to-back read on the RREADY edge; at most one read per 2 cycles.
- Read address check:
  - ADDR[1:0]!=0 -> RDATA=0, RRESP=SLVERR.
  - Otherwise RDATA=register, RRESP=OKAY.
- Simultaneous read and write commit to the same register on one edge: read returns the pre-write value; the new value is visible from the next read.
- regs_o reflects registered contents, updated on the commit edge.
- Word index uses bits [address_width-1:2] only; no wrap logic is needed because every index addresses a real register.

Decomposition:
- Package axi4lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write FSM state enum (WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP), read FSM state enum (RD_IDLE, RD_DATA). The master adopts the same package.
- One sub-module, axi4lite_regfile: NUM_REGS x data_width storage, synchronous reset, one write port (we, widx, wdata), one combinational read port (ridx -> rdata), plus the flattened regs_o.
- Channel FSMs stay in axi4lite_slave.

Test Plan:
- AW 0x08 and W 0xDEADBEEF in the same cycle, BREADY=1 -> BVALID next cycle with BRESP=00; regs_o word 2 = 0xDEADBEEF; AR 0x08 -> RVALID one cycle later, RDATA=0xDEADBEEF, RRESP=00.
- W 0x12345678 three cycles before AW 0x3C -> WREADY low after W capture; BVALID the cycle after AW; read of 0x3C returns 0x12345678.
- AW 0x05 with W 0xFFFFFFFF -> BRESP=10, no register changes; AR 0x05 -> RDATA=0, RRESP=10.
- BREADY held low 4 cycles -> BVALID and BRESP stable, AWREADY=WREADY=0 throughout; read 0x00 with RREADY low 3 cycles -> RDATA stable.
- Write 0x0C=0xA5A5A5A5 and AR 0x0C committing on the same edge, old value 0 -> RDATA=0; a following read returns 0xA5A5A5A5.
- AW 0x10 captured, then ARESET_N low for 1 edge, then W 0x1 -> no BVALID; register 4 stays 0; all outputs at reset values after the reset edge.
